// File: rtl/joypad_pkg.sv
// Shared constants for the NES controller-port model: multitap signatures,
// button bit positions and the serial stream length helper.
package joypad_pkg;

  localparam logic [7:0] SIG_PORT0 = 8'h10;
  localparam logic [7:0] SIG_PORT1 = 8'h20;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // A Four Score port streams both pads followed by its 8-bit signature.
  function automatic int stream_len(input int pad_bits, input int num_pads);
    return (num_pads == 2) ? (2 * pad_bits + 8) : pad_bits;
  endfunction

endpackage

// File: rtl/joypad_turbo.sv
// Turbo toggle for one controller port: flips every TURBO_DIV strobe falling
// edges. Only instantiated when JOYPAD_TURBO_EN is defined.
module joypad_turbo #(
  parameter int TURBO_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic toggle
);

  localparam int CNT_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

  logic             r_strobe_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_toggle;
  logic             w_strobe_fall;

  assign w_strobe_fall = r_strobe_q & ~strobe;
  assign toggle        = r_toggle;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_strobe_q <= 1'b0;
      r_cnt      <= '0;
      r_toggle   <= 1'b0;
    end else begin
      r_strobe_q <= strobe;
      if (w_strobe_fall) begin
        if (r_cnt == CNT_W'(TURBO_DIV - 1)) begin
          r_cnt    <= '0;
          r_toggle <= ~r_toggle;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/joypad_port.sv
// NES controller port: serialises 1 pad, or 2 pads plus a Four Score
// signature, LSB first. Optional turbo masking under JOYPAD_TURBO_EN.
module joypad_port
  import joypad_pkg::*;
#(
  parameter int         PAD_BITS  = 8,
  parameter int         NUM_PADS  = 1,
  parameter logic [7:0] SIGNATURE = SIG_PORT0
`ifdef JOYPAD_TURBO_EN
  ,
  parameter int         TURBO_DIV = 2
`endif
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                strobe,
  input  logic                                                rd,
  input  logic [NUM_PADS*PAD_BITS-1:0]                        btns,
`ifdef JOYPAD_TURBO_EN
  input  logic [NUM_PADS*PAD_BITS-1:0]                        turbo_mask,
`endif
  output logic                                                data,
  output logic [$clog2(stream_len(PAD_BITS, NUM_PADS)+1)-1:0] bit_idx,
  output logic                                                done
);

  localparam int STREAM_LEN = stream_len(PAD_BITS, NUM_PADS);
  localparam int BTN_W      = NUM_PADS * PAD_BITS;
  localparam int IDX_W      = $clog2(STREAM_LEN + 1);

  logic [STREAM_LEN-1:0] r_shift;
  logic [IDX_W-1:0]      r_bit_idx;
  logic                  r_rd_q;

  logic [BTN_W-1:0]      w_btns_eff;
  logic [STREAM_LEN-1:0] w_image;
  logic [STREAM_LEN-1:0] w_shifted;
  logic                  w_rd_fall;

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(STREAM_LEN)) ? v : v + 1'b1;
  endfunction

`ifdef JOYPAD_TURBO_EN
  logic w_toggle;

  joypad_turbo #(
    .TURBO_DIV (TURBO_DIV)
  ) u_turbo (
    .clk    (clk),
    .rst    (rst),
    .strobe (strobe),
    .toggle (w_toggle)
  );

  // Masked buttons only read as pressed during the "on" half of the toggle.
  assign w_btns_eff = btns & (~turbo_mask | {BTN_W{w_toggle}});
`else
  assign w_btns_eff = btns;
`endif

  generate
    if (NUM_PADS == 2) begin : g_multitap
      assign w_image = {SIGNATURE, w_btns_eff};
    end else begin : g_single
      assign w_image = w_btns_eff;
    end
  endgenerate

  // Shift toward bit 0 with 1s entering at the top: an exhausted stream reads pressed.
  assign w_shifted = STREAM_LEN'({1'b1, r_shift} >> 1);
  assign w_rd_fall = r_rd_q & ~rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_rd_q    <= 1'b0;
    end else begin
      r_rd_q <= rd;
      if (strobe) begin
        r_shift   <= w_image;
        r_bit_idx <= '0;
      end else if (w_rd_fall) begin
        r_shift   <= w_shifted;
        r_bit_idx <= sat_inc(r_bit_idx);
      end
    end
  end

  assign data    = r_shift[0];
  assign bit_idx = r_bit_idx;
  assign done    = (r_bit_idx == IDX_W'(STREAM_LEN));

endmodule

// File: tb/tb_joypad_port.sv
// Bench for joypad_port: a single-pad and a two-pad (multitap) instance share
// strobe/rd and are checked against a bit-position model every cycle.
module tb_joypad_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, strobe, rd;
  logic [7:0]  btns1;
  logic [15:0] btns2;
`ifdef JOYPAD_TURBO_EN
  logic [7:0]  tmask1;
  logic [15:0] tmask2;
`endif
  logic        data1, data2, done1, done2;
  logic [3:0]  idx1;
  logic [4:0]  idx2;

  joypad_port #(.PAD_BITS(8), .NUM_PADS(1), .SIGNATURE(8'h10)) dut1 (
    .clk(clk), .rst(rst), .strobe(strobe), .rd(rd), .btns(btns1),
`ifdef JOYPAD_TURBO_EN
    .turbo_mask(tmask1),
`endif
    .data(data1), .bit_idx(idx1), .done(done1));

  joypad_port #(.PAD_BITS(8), .NUM_PADS(2), .SIGNATURE(8'h10)) dut2 (
    .clk(clk), .rst(rst), .strobe(strobe), .rd(rd), .btns(btns2),
`ifdef JOYPAD_TURBO_EN
    .turbo_mask(tmask2),
`endif
    .data(data2), .bit_idx(idx2), .done(done2));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: latched bit list per port and the read position into it.
  logic [31:0] m_img [2];
  int          m_pos [2];
  int          m_len [2];
  logic        m_prev_rd, m_prev_strobe;
  int          m_falls;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_img(input int d);
    logic [7:0]  b1;
    logic [15:0] b2;
    b1 = btns1;
    b2 = btns2;
`ifdef JOYPAD_TURBO_EN
    if (((m_falls / 2) % 2) == 0) begin
      b1 = btns1 & ~tmask1;
      b2 = btns2 & ~tmask2;
    end
`endif
    if (d == 0) return {24'h0, b1};
    return {8'h0, 8'h10, b2};
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_img[d] = '0;
        m_pos[d] = 0;
      end
      m_prev_rd     = 1'b0;
      m_prev_strobe = 1'b0;
      m_falls       = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (strobe) begin
          m_img[d] = load_img(d);
          m_pos[d] = 0;
        end else if (m_prev_rd && !rd && m_pos[d] < m_len[d]) begin
          m_pos[d] = m_pos[d] + 1;
        end
      end
      if (m_prev_strobe && !strobe) m_falls++;
      m_prev_rd     = rd;
      m_prev_strobe = strobe;
    end
  endtask

  function automatic logic exp_data(input int d);
    if (m_pos[d] >= m_len[d]) return 1'b1;
    return m_img[d][m_pos[d]];
  endfunction

  task automatic compare_model();
    check("p1_data", {31'h0, data1}, {31'h0, exp_data(0)});
    check("p1_idx",  {28'h0, idx1},  m_pos[0]);
    check("p1_done", {31'h0, done1}, {31'h0, m_pos[0] == m_len[0]});
    check("p2_data", {31'h0, data2}, {31'h0, exp_data(1)});
    check("p2_idx",  {27'h0, idx2},  m_pos[1]);
    check("p2_done", {31'h0, done2}, {31'h0, m_pos[1] == m_len[1]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic pulse_strobe();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  task automatic do_read(output logic d1, output logic d2);
    rd = 1'b1;
    tick();
    d1 = data1;
    d2 = data2;
    rd = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [7:0]  b1;
    logic [15:0] b2;
    logic [9:0]  exp1;
    logic [25:0] exp2;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic d1, d2;
    logic [7:0] v8;
    logic [7:0] texp;

    m_len[0] = 8;
    m_len[1] = 24;
    vecs[0] = '{8'h09, 16'h8001, 10'h309, 26'h3108001};
    vecs[1] = '{8'hFF, 16'h0000, 10'h3FF, 26'h3100000};
    vecs[2] = '{8'h00, 16'hFFFF, 10'h300, 26'h310FFFF};
    vecs[3] = '{8'hA5, 16'h1234, 10'h3A5, 26'h3101234};

    rst = 1'b1; strobe = 1'b0; rd = 1'b0; btns1 = '0; btns2 = '0;
`ifdef JOYPAD_TURBO_EN
    tmask1 = '0; tmask2 = '0;
`endif
    tick();
    tick();
    check("rst_data1", {31'h0, data1}, 32'd0);
    check("rst_idx1",  {28'h0, idx1},  32'd0);
    check("rst_done1", {31'h0, done1}, 32'd0);
    check("rst_data2", {31'h0, data2}, 32'd0);
    check("rst_idx2",  {27'h0, idx2},  32'd0);
    check("rst_done2", {31'h0, done2}, 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven full streams on both ports.
    for (int v = 0; v < 4; v++) begin
      btns1 = vecs[v].b1;
      btns2 = vecs[v].b2;
      pulse_strobe();
      for (int k = 0; k < 26; k++) begin
        do_read(d1, d2);
        if (k < 10) check($sformatf("tbl%0d_p1_read%0d", v, k + 1), {31'h0, d1}, {31'h0, vecs[v].exp1[k]});
        check($sformatf("tbl%0d_p2_read%0d", v, k + 1), {31'h0, d2}, {31'h0, vecs[v].exp2[k]});
        if (k == 6) check("done1_before_8", {31'h0, done1}, 32'd0);
        if (k == 7) check("done1_after_8",  {31'h0, done1}, 32'd1);
      end
      check("idx1_sat", {28'h0, idx1}, 32'd8);
      check("idx2_sat", {27'h0, idx2}, 32'd24);
      check("done2_end", {31'h0, done2}, 32'd1);
    end

    // Strobe held high while rd toggles: no shifting.
    btns1 = 8'h01;
    strobe = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rd = 1'b1; tick();
      check("hold_data_hi", {31'h0, data1}, 32'd1);
      rd = 1'b0; tick();
      check("hold_data_lo", {31'h0, data1}, 32'd1);
      check("hold_idx",     {28'h0, idx1},  32'd0);
    end
    strobe = 1'b0;

    // rd falling edge coinciding with strobe high.
    btns1 = 8'h01;
    strobe = 1'b1; rd = 1'b1; tick();
    rd = 1'b0; tick();
    check("coinc_idx", {28'h0, idx1}, 32'd0);
    strobe = 1'b0; tick();
    do_read(d1, d2);
    check("coinc_first_read", {31'h0, d1}, 32'd1);
    check("coinc_idx_after",  {28'h0, idx1}, 32'd1);

    // Multi-cycle rd high counts once.
    btns1 = 8'h02;
    pulse_strobe();
    rd = 1'b1; tick(); tick(); tick();
    check("long_rd_stable", {31'h0, data1}, 32'd0);
    rd = 1'b0; tick();
    check("long_rd_idx",  {28'h0, idx1},  32'd1);
    check("long_rd_data", {31'h0, data1}, 32'd1);

    // Reset mid-stream, reads before a strobe, then a fresh stream.
    btns1 = 8'h09;
    pulse_strobe();
    for (int k = 0; k < 3; k++) do_read(d1, d2);
    rst = 1'b1; tick();
    check("midrst_data", {31'h0, data1}, 32'd0);
    check("midrst_idx",  {28'h0, idx1},  32'd0);
    check("midrst_done", {31'h0, done1}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      do_read(d1, d2);
      check($sformatf("nostrobe_read%0d", k + 1), {31'h0, d1}, (k == 8) ? 32'd1 : 32'd0);
    end
    v8 = 8'h5A;
    btns1 = v8;
    pulse_strobe();
    for (int k = 0; k < 8; k++) begin
      do_read(d1, d2);
      check($sformatf("fresh_read%0d", k + 1), {31'h0, d1}, {31'h0, v8[k]});
    end

`ifdef JOYPAD_TURBO_EN
    rst = 1'b1; tick(); rst = 1'b0;
    btns1 = 8'h01; tmask1 = 8'h01; tmask2 = '0;
    texp = 8'b1100_1100;
    for (int f = 0; f < 8; f++) begin
      pulse_strobe();
      do_read(d1, d2);
      check($sformatf("turbo_frame%0d", f + 1), {31'h0, d1}, {31'h0, texp[f]});
    end
`else
    texp = 8'h00;
`endif

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      rst    = ($urandom_range(0, 79) == 0);
      strobe = ($urandom_range(0, 5) == 0);
      rd     = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) begin
        btns1 = 8'($urandom);
        btns2 = 16'($urandom);
`ifdef JOYPAD_TURBO_EN
        tmask1 = 8'($urandom);
        tmask2 = 16'($urandom);
`endif
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
